// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot entry barrier controller.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      OPEN   = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam logic [31:0] PSD_KEY_DEFAULT = 32'd1359;
   localparam int unsigned COUNT_W = 8;

endpackage

// File: rtl/parking_occupancy.sv
// Saturating occupancy counter; simultaneous entry and exit cancel out.
module parking_occupancy
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   output logic [COUNT_W-1:0] count,
   output logic               full
);

   localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);
   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   logic [COUNT_W-1:0] count_d;

   always_comb begin
      count_d = count;
      if (inc && !dec && count != CAP)
         count_d = count + ONE;
      else if (dec && !inc && count != '0)
         count_d = count - ONE;
   end

   // full tracks the next-state count so it lines up with count
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
      end else begin
         count <= count_d;
         full  <= (count_d == CAP);
      end
   end

endmodule

// File: rtl/parking_entry_ctrl.sv
// Entry barrier sequencer: passcode check with lockout, gate timing and occupancy.
//  state  | meaning
//  IDLE   | barrier closed, waiting for a car at the front sensor
//  CHECK  | car present, waiting for a passcode
//  OPEN   | barrier open, waiting for back sensor or timeout
//  LOCKED | too many wrong passcodes, keypad ignored
module parking_entry_ctrl
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY     = 8,
   parameter logic [31:0] PSD_KEY      = PSD_KEY_DEFAULT,
   parameter int unsigned MAX_TRIES    = 3,
   parameter int unsigned LOCK_CYCLES  = 16,
   parameter int unsigned GATE_TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               f_sen,
   input  logic               b_sen,
   input  logic [31:0]        psd,
   input  logic               psd_valid,
   input  logic               exit_pulse,
   output logic               gate,
   output logic               err,
   output logic               lock,
   output logic               timeout,
   output logic               full,
   output logic [COUNT_W-1:0] count
);

   localparam logic [7:0]  TRIES_MAX = 8'(MAX_TRIES);
   localparam logic [31:0] OPEN_LAST = 32'(GATE_TIMEOUT - 1);
   localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  tries_q, tries_d;
   logic [31:0] timer_q, timer_d;
   logic        err_d, timeout_d, inc;

   always_comb begin
      state_d   = state_q;
      tries_d   = tries_q;
      timer_d   = timer_q;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      inc       = 1'b0;
      case (state_q)
         IDLE: begin
            if (f_sen && !full) begin
               state_d = CHECK;
               tries_d = '0;
            end
         end
         CHECK: begin
            // a departing car wins over a keypad strobe in the same cycle
            if (!f_sen) begin
               state_d = IDLE;
               tries_d = '0;
            end else if (psd_valid) begin
               if (psd == PSD_KEY) begin
                  state_d = OPEN;
                  timer_d = '0;
               end else begin
                  err_d   = 1'b1;
                  tries_d = tries_q + 8'd1;
                  if (tries_d == TRIES_MAX) begin
                     state_d = LOCKED;
                     timer_d = '0;
                  end
               end
            end
         end
         OPEN: begin
            if (b_sen) begin
               state_d = IDLE;
               inc     = 1'b1;
            end else if (timer_q == OPEN_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         LOCKED: begin
            if (timer_q == LOCK_LAST) begin
               state_d = IDLE;
               tries_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tries_q <= '0;
         timer_q <= '0;
         gate    <= 1'b0;
         err     <= 1'b0;
         lock    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
         timer_q <= timer_d;
         gate    <= (state_d == OPEN);
         err     <= err_d;
         lock    <= (state_d == LOCKED);
         timeout <= timeout_d;
      end
   end

   parking_occupancy #(
      .CAPACITY (CAPACITY)
   ) u_occupancy (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .dec   (exit_pulse),
      .count (count),
      .full  (full)
   );

endmodule
